// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX operand forwarding,
// load-use stall, branch flush, data-memory busy freeze with timeout fault, stall counter.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_branch_taken,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_wr_en,
    input  logic [REG_ADDR_W-1:0] ex_wr_num,
    input  logic                  ex_is_load,
    input  logic                  mm_wr_en,
    input  logic [REG_ADDR_W-1:0] mm_wr_num,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_wr_num,
    input  logic                  dm_busy,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_bubble,
    output logic                  ex_mm_stall,
    output logic                  mm_wb_bubble,
    output logic                  fault,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]     WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              freeze_s;
    logic              load_use_s;

    // Register 0 is hardwired, so a match on it must never forward; MM is younger than WB.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mm_en,
        input logic [REG_ADDR_W-1:0] mm_num,
        input logic                  wb_en,
        input logic [REG_ADDR_W-1:0] wb_num
    );
        logic [1:0] sel;
        if (src == REG_ZERO) begin
            sel = 2'b00;
        end else if (mm_en && (mm_num == src)) begin
            sel = 2'b01;
        end else if (wb_en && (wb_num == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and control-output decode; reset forces NOPs into the pipe.
    always_comb begin
        load_use_s   = ex_is_load && ex_wr_en && (ex_wr_num != REG_ZERO) &&
                       ((id_uses_rs && (id_rs == ex_wr_num)) ||
                        (id_uses_rt && (id_rt == ex_wr_num)));
        freeze_s     = 1'b0;
        fwd_a_sel    = 2'b00;
        fwd_b_sel    = 2'b00;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mm_stall  = 1'b0;
        mm_wb_bubble = 1'b0;
        fault        = 1'b0;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            mm_wb_bubble = 1'b1;
        end else begin
            fwd_a_sel = fwd_select(ex_rs, mm_wr_en, mm_wr_num, wb_wr_en, wb_wr_num);
            fwd_b_sel = fwd_select(ex_rt, mm_wr_en, mm_wr_num, wb_wr_en, wb_wr_num);
            case (state_r)
                ST_RUN:      freeze_s = dm_busy;
                ST_MEM_WAIT: freeze_s = dm_busy;
                ST_FAULT: begin
                    freeze_s = 1'b1;
                    fault    = 1'b1;
                end
                default: begin
                    freeze_s = 1'b1;
                    fault    = 1'b1;
                end
            endcase
            if (freeze_s) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mm_stall  = 1'b1;
                mm_wb_bubble = 1'b1;
            end else if (load_use_s) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (id_branch_taken) begin
                if_id_flush  = 1'b1;
            end else begin
                if_id_flush  = 1'b0;
            end
        end
    end

    // Counter is reported as zero during the reset cycle, before the register clears.
    assign stall_cycles = reset ? CNT_ZERO : stall_cnt_r;

    // Freeze state machine with data-memory timeout watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= WAIT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (dm_busy) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= WAIT_ONE;
                    end else begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= WAIT_ZERO;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!dm_busy) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= WAIT_ZERO;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ST_FAULT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                end
                default: begin
                    state_r <= ST_FAULT;
                end
            endcase
        end
    end

    // Saturating count of stalled PC cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (pc_stall && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// compared each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int RW = 5;
    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_num, mm_wr_num, wb_wr_num;
    logic          id_uses_rs, id_uses_rt, id_branch_taken, ex_wr_en, ex_is_load;
    logic          mm_wr_en, wb_wr_en, dm_busy;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
    logic          ex_mm_stall, mm_wb_bubble, fault;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Model state: consecutive busy cycles, sticky fault, stalled-cycle count.
    int m_busy_run = 0;
    bit m_fault    = 1'b0;
    int m_cnt      = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(RW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_en(ex_wr_en), .ex_wr_num(ex_wr_num),
        .ex_is_load(ex_is_load),
        .mm_wr_en(mm_wr_en), .mm_wr_num(mm_wr_num), .wb_wr_en(wb_wr_en), .wb_wr_num(wb_wr_num),
        .dm_busy(dm_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_bubble(id_ex_bubble), .ex_mm_stall(ex_mm_stall), .mm_wb_bubble(mm_wb_bubble),
        .fault(fault), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input int src);
        if (src == 0) return 2'd0;
        if (mm_wr_en && int'(mm_wr_num) == src) return 2'd1;
        if (wb_wr_en && int'(wb_wr_num) == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic idle();
        reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_branch_taken = 1'b0; ex_rs = 5'd0; ex_rt = 5'd0; ex_wr_en = 1'b0;
        ex_wr_num = 5'd0; ex_is_load = 1'b0; mm_wr_en = 1'b0; mm_wr_num = 5'd0;
        wb_wr_en = 1'b0; wb_wr_num = 5'd0; dm_busy = 1'b0;
    endtask

    // Compare every output against the model for the current inputs, then clock once.
    task automatic run_cycle();
        bit lu, frz, r;
        #1;
        r   = reset;
        lu  = ex_is_load && ex_wr_en && ex_wr_num != 5'd0 &&
              ((id_uses_rs && id_rs == ex_wr_num) || (id_uses_rt && id_rt == ex_wr_num));
        frz = m_fault || dm_busy;
        check("fwd_a",     {62'd0, fwd_a_sel},  r ? 64'd0 : {62'd0, ref_fwd(int'(ex_rs))});
        check("fwd_b",     {62'd0, fwd_b_sel},  r ? 64'd0 : {62'd0, ref_fwd(int'(ex_rt))});
        check("pc_stall",  {63'd0, pc_stall},    {63'd0, !r && (frz || lu)});
        check("ifid_stall",{63'd0, if_id_stall}, {63'd0, !r && (frz || lu)});
        check("ifid_flush",{63'd0, if_id_flush}, {63'd0, r || (!frz && !lu && id_branch_taken)});
        check("idex_stall",{63'd0, id_ex_stall}, {63'd0, !r && frz});
        check("idex_bub",  {63'd0, id_ex_bubble},{63'd0, r || (!frz && lu)});
        check("exmm_stall",{63'd0, ex_mm_stall}, {63'd0, !r && frz});
        check("mmwb_bub",  {63'd0, mm_wb_bubble},{63'd0, r || frz});
        check("fault",     {63'd0, fault},       {63'd0, !r && m_fault});
        check("stall_cyc", {61'd0, stall_cycles}, r ? 64'd0 : 64'(m_cnt));
        @(posedge clk);
        if (r) begin
            m_busy_run = 0; m_fault = 1'b0; m_cnt = 0;
        end else begin
            if (frz || lu) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
            if (!m_fault) begin
                if (dm_busy) begin
                    m_busy_run++;
                    if (m_busy_run >= TO) m_fault = 1'b1;
                end else begin
                    m_busy_run = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        run_cycle();
        run_cycle();
        idle();
        run_cycle();

        // Load-use: lw $8 in EX, add reading $8 in ID.
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_num = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
        #1;
        check("t1_stall", {63'd0, pc_stall & if_id_stall & id_ex_bubble}, 64'd1);
        run_cycle();
        idle();
        #1;
        check("t1_release", {63'd0, pc_stall | if_id_stall | id_ex_bubble}, 64'd0);
        run_cycle();

        // Forwarding priority and register 0.
        mm_wr_en = 1'b1; mm_wr_num = 5'd9; wb_wr_en = 1'b1; wb_wr_num = 5'd9; ex_rs = 5'd9;
        #1; check("t2_mm", {62'd0, fwd_a_sel}, 64'd1);
        run_cycle();
        mm_wr_en = 1'b0;
        #1; check("t2_wb", {62'd0, fwd_a_sel}, 64'd2);
        run_cycle();
        mm_wr_en = 1'b1; mm_wr_num = 5'd0; ex_rs = 5'd0; ex_rt = 5'd9;
        #1; check("t2_zero", {62'd0, fwd_a_sel}, 64'd0);
        run_cycle();
        idle();

        // Branch flush alone, then masked by load-use.
        id_branch_taken = 1'b1;
        #1; check("t3_flush", {63'd0, if_id_flush}, 64'd1);
        run_cycle();
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_num = 5'd3; id_uses_rt = 1'b1; id_rt = 5'd3;
        #1; check("t3_lu_flush", {63'd0, if_id_flush}, 64'd0);
        run_cycle();
        idle();
        run_cycle();

        // Short busy burst: three frozen cycles, no fault.
        reset = 1'b1; run_cycle(); idle();
        for (int i = 0; i < 3; i++) begin
            dm_busy = 1'b1; ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_num = 5'd4;
            id_uses_rs = 1'b1; id_rs = 5'd4;
            run_cycle();
        end
        idle();
        #1;
        check("t4_cnt", {61'd0, stall_cycles}, 64'd3);
        check("t4_fault", {63'd0, fault}, 64'd0);
        run_cycle();
        run_cycle();

        // Timeout: fault after four busy cycles, sticky, cleared by reset.
        reset = 1'b1; run_cycle(); idle();
        dm_busy = 1'b1;
        for (int i = 0; i < 10; i++) run_cycle();
        dm_busy = 1'b0; id_branch_taken = 1'b1;
        #1;
        check("t5_fault", {63'd0, fault}, 64'd1);
        check("t5_noflush", {63'd0, if_id_flush}, 64'd0);
        run_cycle();
        run_cycle();
        reset = 1'b1; run_cycle(); idle();
        #1; check("t5_cleared", {63'd0, fault}, 64'd0);
        run_cycle();

        // Counter saturation, then reset during the freeze.
        reset = 1'b1; run_cycle(); idle();
        dm_busy = 1'b1;
        for (int i = 0; i < 10; i++) run_cycle();
        #1; check("t6_sat", {61'd0, stall_cycles}, 64'd7);
        reset = 1'b1;
        #1; check("t6_rst_bub", {61'd0, if_id_flush, id_ex_bubble, mm_wb_bubble}, 64'd7);
        run_cycle();
        idle();
        run_cycle();

        // Random traffic over a small register range so hazards collide often.
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 59) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_branch_taken = ($urandom_range(0, 3) == 0);
            ex_rs           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            ex_wr_en        = 1'($urandom_range(0, 1));
            ex_wr_num       = 5'($urandom_range(0, 3));
            ex_is_load      = 1'($urandom_range(0, 1));
            mm_wr_en        = 1'($urandom_range(0, 1));
            mm_wr_num       = 5'($urandom_range(0, 3));
            wb_wr_en        = 1'($urandom_range(0, 1));
            wb_wr_num       = 5'($urandom_range(0, 3));
            dm_busy         = ($urandom_range(0, 4) == 0);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
